demux4_1_buf: RTL

Buffered 1-to-4 demultiplexer for the 8-bit datapath: the distribution counterpart of the 4-to-1 source-select mux. It accepts one 8-bit word per cycle on a valid/ready input port, routes it by a 2-bit destination code into one of four single-entry output holding registers, and presents each channel on its own valid/ready output port. It sits between the ALU/bus driver and the four destination register/port consumers, decoupling a stalled destination from the other three.

---
 rtl/demux4_1_buf.sv | 61 ++++++
 1 files changed

// File: rtl/demux4_1_buf.sv
// Buffered 1-to-4 demux: routes each accepted word by in_dest into a single-entry holding register per channel.
// Latency 1 cycle; in_ready drops only when the addressed channel is full and its consumer is not draining it.
module demux4_1_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_dest,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data0,
  output logic [WIDTH-1:0] out_data1,
  output logic [WIDTH-1:0] out_data2,
  output logic [WIDTH-1:0] out_data3,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [7:0]       xfer_count
);

  logic [WIDTH-1:0] data_q [4];
  logic [3:0]       valid_q;
  logic [7:0]       count_q;
  logic             accept;
  logic [3:0]       load;

  // Readiness looks only at the addressed channel, so a stalled channel never blocks the others.
  assign in_ready = !rst && (!valid_q[in_dest] || out_ready[in_dest]);
  assign accept   = in_valid && in_ready;

  always_comb begin
    load = 4'b0000;
    if (accept) load = 4'b0001 << in_dest;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) data_q[k] <= '0;
      valid_q <= 4'b0000;
      count_q <= 8'h00;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (load[k]) begin
          data_q[k]  <= in_data;
          valid_q[k] <= 1'b1;
        end else if (out_ready[k]) begin
          valid_q[k] <= 1'b0;
        end
      end
      count_q <= count_q + 8'(accept);
    end
  end

  assign out_data0  = data_q[0];
  assign out_data1  = data_q[1];
  assign out_data2  = data_q[2];
  assign out_data3  = data_q[3];
  assign out_valid  = valid_q;
  assign xfer_count = count_q;

endmodule
